// File: rtl/bus_sram_responder_if.sv
// Core-side data/debug bus between a requesting master and the SRAM responder.
// Request channel with busy stall, in-order read/write response channel.
interface bus_sram_responder_if;
    logic        read;
    logic        write;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        busy;
    logic        rvalid;
    logic [31:0] rdata;
    logic [1:0]  resp;
    logic        wrespvalid;

    modport master (
        output read, write, addr, be, wdata,
        input  busy, rvalid, rdata, resp, wrespvalid
    );

    modport slave (
        input  read, write, addr, be, wdata,
        output busy, rvalid, rdata, resp, wrespvalid
    );
endinterface

// File: rtl/bus_sram_responder.sv
// Word-addressed SRAM target for the core data/debug bus, with programmable
// wait states before accept and a fixed-latency in-order response pipeline.
module bus_sram_responder #(
    parameter int unsigned DEPTH_LOG2   = 10,
    parameter logic [31:0] BASE_ADDR    = 32'h0001_0000,
    parameter int unsigned WAIT_STATES  = 0,
    parameter int unsigned RESP_LATENCY = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    bus_sram_responder_if.slave   bus
);

    localparam int unsigned DEPTH  = 1 << DEPTH_LOG2;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned BE_W   = DATA_W / 8;
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned RESP_W = 2;
    localparam int unsigned TAG_LO = DEPTH_LOG2 + 2;

    localparam logic [RESP_W-1:0] RESP_OKAY   = 2'b00;
    localparam logic [RESP_W-1:0] RESP_SLVERR = 2'b10;
    localparam logic [RESP_W-1:0] RESP_DECERR = 2'b11;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    typedef struct packed {
        logic              valid;
        logic              is_write;
        logic [RESP_W-1:0] resp;
        logic [DATA_W-1:0] rdata;
    } resp_t;

    state_t                state;
    state_t                state_next;
    logic [CNT_W-1:0]      cnt;
    logic [CNT_W-1:0]      cnt_next;
    logic                  busy_c;
    logic                  accept;
    logic                  req;
    logic                  both;
    logic                  hit;
    logic                  rd_en;
    logic                  wr_en;
    logic [DEPTH_LOG2-1:0] word_idx;
    resp_t                 stage_in;
    resp_t                 pipe [RESP_LATENCY];
    logic [DATA_W-1:0]     mem  [DEPTH];
    logic                  unused_addr_lsb;

    assign req      = bus.read | bus.write;
    assign both     = bus.read & bus.write;
    assign hit      = (bus.addr[31:TAG_LO] == BASE_ADDR[31:TAG_LO]);
    assign word_idx = bus.addr[DEPTH_LOG2+1:2];
    assign rd_en    = accept & bus.read & ~bus.write & hit;
    assign wr_en    = accept & bus.write & ~bus.read & hit;

    // Byte lanes within a word are selected by be, never by the low address bits.
    assign unused_addr_lsb = ^bus.addr[1:0];

    // Wait-state sequencer register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Wait-state sequencer: every request sees the full wait count before accept.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        busy_c     = 1'b0;
        accept     = 1'b0;
        if (rst_i) begin
            busy_c     = 1'b1;
            state_next = ST_IDLE;
            cnt_next   = '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (req) begin
                        if (WAIT_STATES == 0) begin
                            accept = 1'b1;
                        end else begin
                            busy_c     = 1'b1;
                            cnt_next   = CNT_W'(WAIT_STATES - 1);
                            state_next = ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (!req) begin
                        state_next = ST_IDLE;
                        cnt_next   = '0;
                    end else if (cnt != '0) begin
                        busy_c   = 1'b1;
                        cnt_next = cnt - CNT_W'(1);
                    end else begin
                        accept     = 1'b1;
                        state_next = ST_IDLE;
                    end
                end
                default: begin
                    state_next = ST_IDLE;
                    cnt_next   = '0;
                end
            endcase
        end
    end

    assign bus.busy = busy_c;

    // Response classification for the entry captured at accept.
    always_comb begin
        stage_in          = '0;
        stage_in.valid    = accept;
        stage_in.is_write = bus.write;
        if (both) begin
            stage_in.resp = RESP_SLVERR;
        end else if (!hit) begin
            stage_in.resp = RESP_DECERR;
        end else begin
            stage_in.resp = RESP_OKAY;
        end
    end

    // Storage array; contents survive reset.
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            for (int i = 0; i < BE_W; i++) begin
                if (bus.be[i]) begin
                    mem[word_idx][8*i +: 8] <= bus.wdata[8*i +: 8];
                end
            end
        end
    end

    // Fixed-latency response shift pipeline; read data is sampled at accept.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < RESP_LATENCY; i++) begin
                pipe[i] <= '0;
            end
        end else begin
            pipe[0].valid    <= stage_in.valid;
            pipe[0].is_write <= stage_in.is_write;
            pipe[0].resp     <= stage_in.valid ? stage_in.resp : RESP_OKAY;
            pipe[0].rdata    <= rd_en ? mem[word_idx] : '0;
            for (int i = 1; i < RESP_LATENCY; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    assign bus.rvalid     = pipe[RESP_LATENCY-1].valid & ~pipe[RESP_LATENCY-1].is_write;
    assign bus.wrespvalid = pipe[RESP_LATENCY-1].valid &  pipe[RESP_LATENCY-1].is_write;
    assign bus.resp       = pipe[RESP_LATENCY-1].resp;
    assign bus.rdata      = pipe[RESP_LATENCY-1].rdata;

endmodule
